// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the up/down counter.
//   BCD_W / BCD_MAX / BCD_MIN : digit width and legal digit range
//   bcd_clamp(nibble)         : maps an illegal nibble (>9) to 9
//   is_all_nines(vec, n)      : 1 when the low n digits of vec are all 9
package bcd_pkg;
   localparam int         BCD_W   = 4;
   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BCD_MIN = 4'd0;

   function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] nibble);
      return (nibble > BCD_MAX) ? BCD_MAX : nibble;
   endfunction

   // vec is zero-extended to 8 digits; only the low n digits are inspected
   function automatic logic is_all_nines(input logic [31:0] vec, input int n);
      logic r;
      r = 1'b1;
      for (int i = 0; i < 8; i++)
         if (i < n && vec[i*BCD_W +: BCD_W] != BCD_MAX) r = 1'b0;
      return r;
   endfunction
endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control/status bundle of the BCD up/down counter.
//   en, up, load, load_val : driven by the master (controller / testbench)
//   cnt, tc, ovf, ld_err   : driven by the counter (slave)
interface bcd_updown_counter_if #(
   parameter int DIGITS = 2
);
   logic                  en;
   logic                  up;
   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
   logic [4*DIGITS-1:0]   cnt;
   logic                  tc;
   logic                  ovf;
   logic                  ld_err;

   modport master (output en, up, load, load_val, input cnt, tc, ovf, ld_err);
   modport slave  (input en, up, load, load_val, output cnt, tc, ovf, ld_err);
endinterface

// File: rtl/bcd_digit_cell.sv
// One combinational BCD digit of the counter chain.
//   cur      : current stored digit      up    : 1 = increment, 0 = decrement
//   cin      : carry/borrow in (step)    load  : parallel load, load_dig = value
//   rst      : reset, forces RST_DIGIT
//   nxt      : next digit value          cout  : carry/borrow into the next digit
module bcd_digit_cell
   import bcd_pkg::*;
#(
   parameter logic [BCD_W-1:0] RST_DIGIT = 4'd0
) (
   input  logic [BCD_W-1:0] cur,
   input  logic             up,
   input  logic             cin,
   input  logic             load,
   input  logic [BCD_W-1:0] load_dig,
   input  logic             rst,
   output logic [BCD_W-1:0] nxt,
   output logic             cout
);
   always_comb begin
      nxt  = cur;
      cout = 1'b0;
      if (rst) begin
         nxt = RST_DIGIT;
      end else if (load) begin
         nxt = bcd_clamp(load_dig);
      end else if (cin) begin
         if (up) begin
            // an illegal digit is treated like 9: goes to 0 and carries
            if (cur >= BCD_MAX) begin
               nxt  = BCD_MIN;
               cout = 1'b1;
            end else begin
               nxt = cur + 4'd1;
            end
         end else begin
            // an illegal digit snaps to 9 without borrowing
            if (cur > BCD_MAX) begin
               nxt = BCD_MAX;
            end else if (cur == BCD_MIN) begin
               nxt  = BCD_MAX;
               cout = 1'b1;
            end else begin
               nxt = cur - 4'd1;
            end
         end
      end
   end
endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit packed-BCD up/down counter with load, wrap/saturate and flags.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : slave side of bcd_updown_counter_if
//              en/up/load/load_val in; cnt (registered), tc (combinational),
//              ovf and ld_err (registered one-cycle pulses) out
module bcd_updown_counter
   import bcd_pkg::*;
#(
   parameter int                  DIGITS    = 2,
   parameter logic [4*DIGITS-1:0] RESET_VAL = '0,
   parameter bit                  SATURATE  = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   bcd_updown_counter_if.slave   bus
);
   localparam int            CW        = BCD_W * DIGITS;
   localparam logic [CW-1:0] ALL_NINES = {DIGITS{BCD_MAX}};

   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   chain_nxt;
   logic [CW-1:0]   cnt_d;
   logic [DIGITS:0] carry;
   logic [DIGITS-1:0] bad;
   logic            ovf_q;
   logic            ld_err_q;
   logic            ovf_d;
   logic            ld_err_d;

   // digit 0 steps whenever counting is enabled; each cell passes carry/borrow up
   assign carry[0] = bus.en;

   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      bcd_digit_cell #(
         .RST_DIGIT (RESET_VAL[i*BCD_W +: BCD_W])
      ) u_cell (
         .cur      (cnt_q[i*BCD_W +: BCD_W]),
         .up       (bus.up),
         .cin      (carry[i]),
         .load     (bus.load),
         .load_dig (bus.load_val[i*BCD_W +: BCD_W]),
         .rst      (rst),
         .nxt      (chain_nxt[i*BCD_W +: BCD_W]),
         .cout     (carry[i+1])
      );
      assign bad[i] = bus.load_val[i*BCD_W +: BCD_W] > BCD_MAX;
   end

   // carry out of the top digit is the wrap event; loads suppress the chain,
   // so ovf and ld_err can never coincide
   always_comb begin
      cnt_d    = chain_nxt;
      ovf_d    = carry[DIGITS];
      ld_err_d = bus.load & (|bad);
      // saturate to the legal extreme rather than holding cnt_q, so an
      // illegal top digit is still cleaned up in saturate mode
      if (SATURATE && carry[DIGITS])
         cnt_d = bus.up ? ALL_NINES : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= RESET_VAL;
         ovf_q    <= 1'b0;
         ld_err_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         ld_err_q <= ld_err_d;
      end
   end

   assign bus.cnt    = cnt_q;
   assign bus.ovf    = ovf_q;
   assign bus.ld_err = ld_err_q;
   assign bus.tc     = bus.en & (bus.up ? is_all_nines(32'(cnt_q), DIGITS)
                                        : (cnt_q == '0));
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench: three counters (wrap, saturate, RESET_VAL=42) share
// one stimulus stream and are compared against an integer-arithmetic model.
module tb_bcd_updown_counter;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0, up = 1'b1, load = 1'b0;
   logic [7:0] load_val = 8'h00;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bcd_updown_counter_if #(.DIGITS(2)) if_a ();
   bcd_updown_counter_if #(.DIGITS(2)) if_b ();
   bcd_updown_counter_if #(.DIGITS(2)) if_c ();

   assign if_a.en = en;  assign if_a.up = up;  assign if_a.load = load;  assign if_a.load_val = load_val;
   assign if_b.en = en;  assign if_b.up = up;  assign if_b.load = load;  assign if_b.load_val = load_val;
   assign if_c.en = en;  assign if_c.up = up;  assign if_c.load = load;  assign if_c.load_val = load_val;

   bcd_updown_counter #(.DIGITS(2), .RESET_VAL(8'h00), .SATURATE(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
   bcd_updown_counter #(.DIGITS(2), .RESET_VAL(8'h00), .SATURATE(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
   bcd_updown_counter #(.DIGITS(2), .RESET_VAL(8'h42), .SATURATE(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

   logic [7:0] o_cnt [3];
   logic       o_ovf [3];
   logic       o_lde [3];
   logic       o_tc  [3];
   assign o_cnt[0] = if_a.cnt;  assign o_ovf[0] = if_a.ovf;  assign o_lde[0] = if_a.ld_err;  assign o_tc[0] = if_a.tc;
   assign o_cnt[1] = if_b.cnt;  assign o_ovf[1] = if_b.ovf;  assign o_lde[1] = if_b.ld_err;  assign o_tc[1] = if_b.tc;
   assign o_cnt[2] = if_c.cnt;  assign o_ovf[2] = if_c.ovf;  assign o_lde[2] = if_c.ld_err;  assign o_tc[2] = if_c.tc;

   // ---------------- reference model (decimal arithmetic) ----------------
   logic [7:0] m_cnt [3];
   logic       m_ovf [3];
   logic       m_lde [3];

   function automatic logic [7:0] rv(int k);
      return (k == 2) ? 8'h42 : 8'h00;
   endfunction

   function automatic bit sat(int k);
      return (k == 1);
   endfunction

   function automatic int to_int(logic [7:0] v);
      return int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic logic [7:0] to_bcd(int n);
      logic [3:0] hi, lo;
      hi = 4'(n / 10);
      lo = 4'(n % 10);
      return {hi, lo};
   endfunction

   function automatic void model_step(int k);
      int         n;
      logic [7:0] cl;
      logic [3:0] nib;
      bit         bad;
      m_ovf[k] = 1'b0;
      m_lde[k] = 1'b0;
      if (rst) begin
         m_cnt[k] = rv(k);
      end else if (load) begin
         bad = 1'b0;
         cl  = 8'h00;
         for (int d = 0; d < 2; d++) begin
            nib = load_val[d*4 +: 4];
            if (nib > 4'd9) begin nib = 4'd9; bad = 1'b1; end
            cl[d*4 +: 4] = nib;
         end
         m_cnt[k] = cl;
         m_lde[k] = bad;
      end else if (en) begin
         n = to_int(m_cnt[k]);
         if (up) begin
            if (n == 99) begin m_ovf[k] = 1'b1; n = sat(k) ? 99 : 0; end
            else n = n + 1;
         end else begin
            if (n == 0) begin m_ovf[k] = 1'b1; n = sat(k) ? 0 : 99; end
            else n = n - 1;
         end
         m_cnt[k] = to_bcd(n);
      end
   endfunction

   function automatic logic exp_tc(int k);
      return en & (up ? (m_cnt[k] == 8'h99) : (m_cnt[k] == 8'h00));
   endfunction

   // one clock edge; model advances with the inputs sampled at that edge
   task automatic tick();
      @(posedge clk);
      for (int k = 0; k < 3; k++) model_step(k);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (o_cnt[k] !== rv(k) || o_ovf[k] !== 1'b0 || o_lde[k] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset inst%0d: cnt=%h ovf=%b lde=%b, want cnt=%h ovf=0 lde=0",
                     k, o_cnt[k], o_ovf[k], o_lde[k], rv(k));
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_count_up();
      int ovf_seen = 0;
      int tc_seen  = 0;
      en = 1'b1; up = 1'b1; load = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (o_ovf[0] === 1'b1) ovf_seen++;
         if (o_tc[0] === 1'b1) begin
            tc_seen++;
            n_cmp++;
            if (o_cnt[0] !== 8'h99) begin
               n_bad++;
               $display("FAIL count_up_tc: tc=1 with cnt=%h, want only at 99", o_cnt[0]);
            end
         end
         for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (o_cnt[k] !== m_cnt[k] || o_ovf[k] !== m_ovf[k] || o_lde[k] !== m_lde[k] || o_tc[k] !== exp_tc(k)) begin
               n_bad++;
               $display("FAIL count_up inst%0d step%0d: cnt=%h/%h ovf=%b/%b lde=%b/%b tc=%b/%b (got/want)",
                        k, i, o_cnt[k], m_cnt[k], o_ovf[k], m_ovf[k], o_lde[k], m_lde[k], o_tc[k], exp_tc(k));
            end
         end
      end
      n_cmp++;
      if (o_cnt[0] !== 8'h00 || ovf_seen != 1 || tc_seen != 1) begin
         n_bad++;
         $display("FAIL count_up_wrap: cnt=%h ovf_pulses=%0d tc_cycles=%0d, want 00/1/1",
                  o_cnt[0], ovf_seen, tc_seen);
      end
   endtask

   task automatic test_load_down();
      logic [7:0] want [5] = '{8'h10, 8'h09, 8'h08, 8'h00, 8'h99};
      for (int s = 0; s < 5; s++) begin
         en = 1'b1; up = 1'b0;
         load = (s == 0 || s == 3);
         load_val = (s == 0) ? 8'h10 : 8'h00;
         tick();
         n_cmp++;
         if (o_cnt[0] !== want[s] || o_ovf[0] !== (s == 4)) begin
            n_bad++;
            $display("FAIL load_down step%0d: cnt=%h ovf=%b, want cnt=%h ovf=%b",
                     s, o_cnt[0], o_ovf[0], want[s], (s == 4));
         end
         for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (o_cnt[k] !== m_cnt[k] || o_ovf[k] !== m_ovf[k] || o_lde[k] !== m_lde[k] || o_tc[k] !== exp_tc(k)) begin
               n_bad++;
               $display("FAIL load_down inst%0d: cnt=%h/%h ovf=%b/%b lde=%b/%b tc=%b/%b (got/want)",
                        k, o_cnt[k], m_cnt[k], o_ovf[k], m_ovf[k], o_lde[k], m_lde[k], o_tc[k], exp_tc(k));
            end
         end
      end
      load = 1'b0;
   endtask

   task automatic test_saturate();
      for (int dir = 0; dir < 2; dir++) begin
         up = (dir == 0); en = 1'b1; load = 1'b1;
         load_val = (dir == 0) ? 8'h98 : 8'h01;
         tick();
         load = 1'b0;
         for (int s = 0; s < 3; s++) begin
            tick();
            n_cmp++;
            if (o_cnt[1] !== ((dir == 0) ? 8'h99 : 8'h00) || o_ovf[1] !== (s > 0)) begin
               n_bad++;
               $display("FAIL saturate dir%0d step%0d: cnt=%h ovf=%b, want cnt=%h ovf=%b",
                        dir, s, o_cnt[1], o_ovf[1], (dir == 0) ? 8'h99 : 8'h00, (s > 0));
            end
            for (int k = 0; k < 3; k++) begin
               n_cmp++;
               if (o_cnt[k] !== m_cnt[k] || o_ovf[k] !== m_ovf[k] || o_tc[k] !== exp_tc(k)) begin
                  n_bad++;
                  $display("FAIL saturate inst%0d: cnt=%h/%h ovf=%b/%b tc=%b/%b (got/want)",
                           k, o_cnt[k], m_cnt[k], o_ovf[k], m_ovf[k], o_tc[k], exp_tc(k));
               end
            end
         end
      end
   endtask

   task automatic test_load_err();
      logic [7:0] vals [3] = '{8'hA7, 8'hFF, 8'h5A};
      logic [7:0] want [3] = '{8'h97, 8'h99, 8'h59};
      for (int s = 0; s < 3; s++) begin
         en = 1'b0; load = 1'b1; load_val = vals[s];
         tick();
         n_cmp++;
         if (o_cnt[0] !== want[s] || o_lde[0] !== 1'b1 || o_ovf[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL load_err %h: cnt=%h lde=%b ovf=%b, want cnt=%h lde=1 ovf=0",
                     vals[s], o_cnt[0], o_lde[0], o_ovf[0], want[s]);
         end
         load = 1'b0;
         tick();
         n_cmp++;
         if (o_cnt[0] !== want[s] || o_lde[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL load_err_clear %h: cnt=%h lde=%b, want cnt=%h lde=0",
                     vals[s], o_cnt[0], o_lde[0], want[s]);
         end
      end
   endtask

   task automatic test_illegal();
      logic [7:0] want [2] = '{8'h40, 8'h39};
      bit         inj;
      for (int s = 0; s < 2; s++) begin
         en = 1'b1; up = (s == 0); load = 1'b0; rst = 1'b0;
         force dut_a.cnt_q = 8'h3C;
         release dut_a.cnt_q;
         #0;
         inj = (dut_a.cnt_q === 8'h3C);
         if (!inj) $display("note: illegal-digit injection unavailable, step %0d uses legal value", s);
         tick();
         if (inj) begin
            m_cnt[0] = want[s];
            m_ovf[0] = 1'b0;
         end
         n_cmp++;
         if (o_cnt[0] !== m_cnt[0] || o_ovf[0] !== m_ovf[0]) begin
            n_bad++;
            $display("FAIL illegal_digit up=%b: cnt=%h ovf=%b, want cnt=%h ovf=%b",
                     up, o_cnt[0], o_ovf[0], m_cnt[0], m_ovf[0]);
         end
      end
   endtask

   task automatic test_priority();
      // load beats enable
      en = 1'b1; up = 1'b1; load = 1'b1; load_val = 8'h55;
      tick();
      n_cmp++;
      if (o_cnt[0] !== 8'h55 || o_cnt[2] !== 8'h55 || o_ovf[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL load_over_en: cnt=%h/%h ovf=%b, want 55/55 ovf=0", o_cnt[0], o_cnt[2], o_ovf[0]);
      end
      // reset beats an illegal load
      rst = 1'b1; load_val = 8'hBB;
      tick();
      n_cmp++;
      if (o_cnt[0] !== 8'h00 || o_cnt[2] !== 8'h42 || o_lde[0] !== 1'b0 || o_lde[2] !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_over_load: cnt=%h/%h lde=%b/%b, want 00/42 lde=0/0",
                  o_cnt[0], o_cnt[2], o_lde[0], o_lde[2]);
      end
      // count from 42 then reset mid-count
      rst = 1'b0; load = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      n_cmp++;
      if (o_cnt[2] !== 8'h47) begin
         n_bad++;
         $display("FAIL count_from_42: cnt=%h, want 47", o_cnt[2]);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++;
      if (o_cnt[2] !== 8'h42 || o_ovf[2] !== 1'b0 || o_lde[2] !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mid_count: cnt=%h ovf=%b lde=%b, want 42/0/0", o_cnt[2], o_ovf[2], o_lde[2]);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         en   = 1'($urandom_range(0, 1));
         if (i % 3 == 0) up = ~up;
         load = ($urandom_range(0, 15) == 0);
         load_val = 8'($urandom);
         rst  = ($urandom_range(0, 63) == 0);
         tick();
         for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (o_cnt[k] !== m_cnt[k] || o_ovf[k] !== m_ovf[k] || o_lde[k] !== m_lde[k] || o_tc[k] !== exp_tc(k)
                || (o_ovf[k] & o_lde[k])) begin
               n_bad++;
               $display("FAIL random inst%0d cyc%0d: cnt=%h/%h ovf=%b/%b lde=%b/%b tc=%b/%b (got/want)",
                        k, i, o_cnt[k], m_cnt[k], o_ovf[k], m_ovf[k], o_lde[k], m_lde[k], o_tc[k], exp_tc(k));
            end
         end
      end
      rst = 1'b0; load = 1'b0; en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_load_down();
      test_saturate();
      test_load_err();
      test_illegal();
      test_priority();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
